rr_arb2_sel: RTL

- Two-input round-robin arbiter with a registered output stage.
- Sits directly upstream of the 2:1 select path. It decides which of two valid/ready sources drives the shared output, generates the select, muxes the data and registers the result.
- Provides one-cycle latency, fair alternation under contention and full back-pressure support.

---
 rtl/rr_arb2_pkg.sv | 16 +
 rtl/mux2_w.sv | 23 ++
 rtl/rr_arb2_sel.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rr_arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2_pkg
// Brief   : Shared types and constants for the two-input round-robin arbiter.
// Revision: 1.0  initial release
// ============================================================================
package rr_arb2_pkg;

    typedef logic src_t;

    localparam src_t SRC_A   = 1'b0;
    localparam src_t SRC_B   = 1'b1;
    localparam int   STATS_W = 16;

endpackage : rr_arb2_pkg
`default_nettype wire

// File: rtl/mux2_w.sv
`default_nettype none
// ============================================================================
// Module  : mux2_w
// Brief   : Width-parameterised combinational 2:1 data select.
// Revision: 1.0  initial release
// ============================================================================
module mux2_w
    import rr_arb2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  src_t              sel,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = (sel == SRC_B) ? d1 : d0;
    end

endmodule : mux2_w
`default_nettype wire

// File: rtl/rr_arb2_sel.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2_sel
// Brief   : Two-input round-robin arbiter with registered select/data output.
//           Optional per-source transfer counters under RR_ARB2_STATS_EN.
// Revision: 1.0  initial release
// ============================================================================
module rr_arb2_sel
    import rr_arb2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_sel,
    input  logic              y_ready
`ifdef RR_ARB2_STATS_EN
    ,
    output logic [STATS_W-1:0] cnt_a,
    output logic [STATS_W-1:0] cnt_b
`endif
);

    logic              w_load;
    logic              w_any;
    logic              w_xfer;
    src_t              w_grant;
    logic [DATA_W-1:0] w_mux_data;

    logic              y_valid_q,    y_valid_d;
    logic [DATA_W-1:0] y_data_q,     y_data_d;
    src_t              y_sel_q,      y_sel_d;
    src_t              last_grant_q, last_grant_d;

    // Under contention the source that did not win last time is served.
    always_comb begin
        w_any = a_valid | b_valid;
        if (a_valid && b_valid) begin
            w_grant = (last_grant_q == SRC_A) ? SRC_B : SRC_A;
        end else if (b_valid) begin
            w_grant = SRC_B;
        end else begin
            w_grant = SRC_A;
        end
    end

    // rst_n gating keeps both readies low while the block is held in reset.
    always_comb begin
        w_load  = rst_n & (~y_valid_q | y_ready);
        w_xfer  = w_load & w_any;
        a_ready = w_load & a_valid & (w_grant == SRC_A);
        b_ready = w_load & b_valid & (w_grant == SRC_B);
    end

    mux2_w #(
        .DATA_W (DATA_W)
    ) u_mux (
        .sel (w_grant),
        .d0  (a_data),
        .d1  (b_data),
        .y   (w_mux_data)
    );

    always_comb begin
        y_valid_d    = y_valid_q;
        y_data_d     = y_data_q;
        y_sel_d      = y_sel_q;
        last_grant_d = last_grant_q;
        if (w_xfer) begin
            y_valid_d    = 1'b1;
            y_data_d     = w_mux_data;
            y_sel_d      = w_grant;
            last_grant_d = w_grant;
        end else if (w_load) begin
            y_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid_q    <= 1'b0;
            y_data_q     <= '0;
            y_sel_q      <= SRC_A;
            last_grant_q <= SRC_B;
        end else begin
            y_valid_q    <= y_valid_d;
            y_data_q     <= y_data_d;
            y_sel_q      <= y_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        y_valid = y_valid_q;
        y_data  = y_data_q;
        y_sel   = y_sel_q;
    end

`ifdef RR_ARB2_STATS_EN
    logic [STATS_W-1:0] cnt_a_q, cnt_a_d;
    logic [STATS_W-1:0] cnt_b_q, cnt_b_d;

    // Counters wrap naturally at the top of their range.
    always_comb begin
        cnt_a_d = cnt_a_q + {{(STATS_W-1){1'b0}}, a_ready};
        cnt_b_d = cnt_b_q + {{(STATS_W-1){1'b0}}, b_ready};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    always_comb begin
        cnt_a = cnt_a_q;
        cnt_b = cnt_b_q;
    end
`endif

endmodule : rr_arb2_sel
`default_nettype wire
